// File: rtl/aes_inv_key_expansion.sv
// Decrypt-side AES-128 key schedule: runs forward to the round-10 key, then steps back one round key per handshake.
// Optional AES_INV_KEY_EQ_EN adds an InvMixColumns view of the round key for the equivalent inverse cipher.
module aes_inv_key_expansion #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         Valid,
  input  logic [127:0] Key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   key_rnd,
  output logic         busy,
  output logic [127:0] key_eq_out
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_busy, w_busy_nxt;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_p3, w_rot, w_t;
  logic [3:0]   w_rcon_idx;
  logic [127:0] w_fwd_key, w_rev_key;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_p3 = w_w3 ^ w_w2;

  // One SubWord datapath serves both directions: RotWord(w3) going forward, RotWord(p3) going back.
  assign w_rot      = (r_state == REV) ? {w_p3[23:0], w_p3[31:24]} : {w_w3[23:0], w_w3[31:24]};
  assign w_rcon_idx = (r_state == REV) ? r_rnd : r_rnd + 4'd1;
  assign w_t        = sub_word(w_rot) ^ {rcon(w_rcon_idx), 24'h0};

  assign w_n0      = w_w0 ^ w_t;
  assign w_n1      = w_n0 ^ w_w1;
  assign w_n2      = w_n1 ^ w_w2;
  assign w_n3      = w_n2 ^ w_w3;
  assign w_fwd_key = {w_n0, w_n1, w_n2, w_n3};
  assign w_rev_key = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3};

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_rnd_nxt   = r_rnd;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    if (Valid) begin
      w_state_nxt = FWD;
      w_key_nxt   = Key_in;
      w_rnd_nxt   = 4'd0;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        FWD: begin
          w_key_nxt = w_fwd_key;
          w_rnd_nxt = r_rnd + 4'd1;
          if (r_rnd == LAST_RND - 4'd1) begin
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = REV;
          end
        end
        REV: begin
          if (r_valid && key_ready) begin
            if (r_rnd != 4'd0) begin
              w_key_nxt = w_rev_key;
              w_rnd_nxt = r_rnd - 4'd1;
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_rnd   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_rnd   <= w_rnd_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign key_out   = r_key;
  assign key_rnd   = r_rnd;
  assign key_valid = r_valid;
  assign busy      = r_busy;

`ifdef AES_INV_KEY_EQ_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]   = c[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  // First and last round keys are used unmixed by the equivalent inverse cipher.
  assign key_eq_out = (r_rnd == 4'd0 || r_rnd == LAST_RND) ? r_key :
                      {inv_mix_col(w_w0), inv_mix_col(w_w1), inv_mix_col(w_w2), inv_mix_col(w_w3)};
`else
  assign key_eq_out = r_key;
`endif

endmodule
